filter_stack_router: RTL and testbench

//  Parametrised, frame-synchronous selector for the chained pixel-filter stack.

---
 rtl/filter_stack_router.sv | 157 +++++++++++++++
 tb/tb_filter_stack_router.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_stack_router.sv
// Frame-synchronous output selector for the chained pixel-filter stack.
// Chooses a tap depth from BPM bands and a beat boost; depth changes land only on the chosen tap's start of frame.
module filter_stack_router #(
  parameter int DATA_W           = 8,
  parameter int NUM_STAGES       = 4,
  parameter int BPM_W            = 16,
  parameter logic [(NUM_STAGES-1)*BPM_W-1:0] THRESH = {16'd100, 16'd140, 16'd180},
  parameter int HYST_FRAMES      = 2,
  parameter int BEAT_HOLD_FRAMES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [DATA_W-1:0]                 pixel_in,
  input  logic                              pixel_valid_in,
  input  logic                              sof_in,
  input  logic [BPM_W-1:0]                  BPM_estimate,
  input  logic                              beat_detected,
  input  logic [NUM_STAGES*DATA_W-1:0]      stage_pixel,
  input  logic [NUM_STAGES-1:0]             stage_valid,
  input  logic [NUM_STAGES-1:0]             stage_sof,
  output logic [DATA_W-1:0]                 pixel_out,
  output logic                              pixel_valid_out,
  output logic                              sof_out,
  output logic [$clog2(NUM_STAGES+1)-1:0]   active_depth,
  output logic                              depth_change
);

  localparam int DEPTH_W = $clog2(NUM_STAGES + 1);
  localparam int SUM_W   = DEPTH_W + 1;
  localparam int HC_W    = $clog2(HYST_FRAMES + 1);
  localparam int BOOST_W = $clog2(BEAT_HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, RUN} state_t;

  state_t              state, state_nxt;
  logic [DEPTH_W-1:0]  sel_depth, candidate;
  logic [DEPTH_W-1:0]  active_nxt, cand_nxt, target, out_sel;
  logic [HC_W-1:0]     hyst_cnt, hc_nxt, hc_inc;
  logic [BOOST_W-1:0]  boost_cnt;
  logic [SUM_W-1:0]    base, sum;
  logic                muted;
  logic                fe, boosted, trig, commit, out_en, out_fire;

  // Tap 0 is the raw stream; taps 1..NUM_STAGES are the filter outputs.
  logic [DATA_W-1:0]   tap_pixel [NUM_STAGES+1];
  logic [NUM_STAGES:0] tap_valid, tap_sof;

  assign tap_valid    = {stage_valid, pixel_valid_in};
  assign tap_sof      = {stage_sof, sof_in};
  assign tap_pixel[0] = pixel_in;

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_tap
    assign tap_pixel[k] = stage_pixel[k*DATA_W-1 -: DATA_W];
  end

  assign fe      = sof_in & pixel_valid_in;
  assign boosted = (beat_detected & enable) | (boost_cnt != '0);
  assign hc_inc  = hyst_cnt + HC_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    base = SUM_W'(1);
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      if (THRESH[i*BPM_W +: BPM_W] <= BPM_estimate) base = base + SUM_W'(1);
    end
    sum = base + SUM_W'(boosted);
    if (!enable)                          target = '0;
    else if (sum > SUM_W'(NUM_STAGES))    target = DEPTH_W'(NUM_STAGES);
    else                                  target = sum[DEPTH_W-1:0];
  end

  // A pending switch fires on the committed tap's own start of frame; depth 0 reduces to fe.
  assign trig = (state == PENDING) & tap_sof[active_depth] & tap_valid[active_depth];

  always_comb begin
    state_nxt  = state;
    active_nxt = active_depth;
    cand_nxt   = candidate;
    hc_nxt     = hyst_cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (fe) begin
          commit     = 1'b1;
          active_nxt = target;
          cand_nxt   = target;
          hc_nxt     = '0;
          state_nxt  = PENDING;
        end
      end
      PENDING, RUN: begin
        if (trig) state_nxt = RUN;
        if (fe) begin
          if (target == active_depth) begin
            hc_nxt = '0;
          end else begin
            if (target == candidate) begin
              hc_nxt = hc_inc;
            end else begin
              cand_nxt = target;
              hc_nxt   = HC_W'(1);
            end
            if (hc_nxt == HC_W'(HYST_FRAMES)) begin
              commit     = 1'b1;
              active_nxt = target;
              hc_nxt     = '0;
              state_nxt  = PENDING;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output stays muted from reset until the first selected start of frame.
  assign out_sel  = trig ? active_depth : sel_depth;
  assign out_en   = ~muted | trig;
  assign out_fire = tap_valid[out_sel] & out_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      active_depth    <= '0;
      sel_depth       <= '0;
      candidate       <= '0;
      hyst_cnt        <= '0;
      boost_cnt       <= '0;
      muted           <= 1'b1;
      depth_change    <= 1'b0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      sof_out         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state        <= state_nxt;
      active_depth <= active_nxt;
      candidate    <= cand_nxt;
      hyst_cnt     <= hc_nxt;
      depth_change <= commit;

      if (beat_detected && enable)       boost_cnt <= BOOST_W'(BEAT_HOLD_FRAMES);
      else if (fe && boost_cnt != '0)    boost_cnt <= boost_cnt - BOOST_W'(1);

      if (trig) begin
        sel_depth <= active_depth;
        muted     <= 1'b0;
      end

      pixel_valid_out <= out_fire;
      sof_out         <= out_fire & tap_sof[out_sel];
      if (out_fire) pixel_out <= tap_pixel[out_sel];
    end
  end

endmodule

// File: tb/tb_filter_stack_router.sv
// Self-checking bench: two routers (hysteresis 2 and 1) share randomized frame stimulus
// and are compared every cycle against a frame-level reference model, plus directed checks.
module tb_filter_stack_router;

  localparam int DATA_W     = 8;
  localparam int NUM_STAGES = 4;
  localparam int BPM_W      = 16;
  localparam int DEPTH_W    = 3;
  localparam int TAP_LAG    = 3;
  localparam int FRAME_LEN  = 16;
  localparam int HIST       = NUM_STAGES * TAP_LAG + 1;
  localparam int BEAT_HOLD  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [DATA_W-1:0] pixel_in = '0;
  logic pixel_valid_in = 1'b0;
  logic sof_in = 1'b0;
  logic [BPM_W-1:0] BPM_estimate = '0;
  logic beat_detected = 1'b0;
  logic [NUM_STAGES*DATA_W-1:0] stage_pixel = '0;
  logic [NUM_STAGES-1:0] stage_valid = '0;
  logic [NUM_STAGES-1:0] stage_sof = '0;

  logic [DATA_W-1:0]  o_pix [2];
  logic [1:0]         o_val, o_sof, o_dc;
  logic [DEPTH_W-1:0] o_act [2];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int dc_seen [2];

  always #5 clk = ~clk;

  filter_stack_router #(.HYST_FRAMES(2)) dut_h2 (
    .clk(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
    .pixel_valid_in(pixel_valid_in), .sof_in(sof_in), .BPM_estimate(BPM_estimate),
    .beat_detected(beat_detected), .stage_pixel(stage_pixel), .stage_valid(stage_valid),
    .stage_sof(stage_sof), .pixel_out(o_pix[0]), .pixel_valid_out(o_val[0]),
    .sof_out(o_sof[0]), .active_depth(o_act[0]), .depth_change(o_dc[0])
  );

  filter_stack_router #(.HYST_FRAMES(1)) dut_h1 (
    .clk(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
    .pixel_valid_in(pixel_valid_in), .sof_in(sof_in), .BPM_estimate(BPM_estimate),
    .beat_detected(beat_detected), .stage_pixel(stage_pixel), .stage_valid(stage_valid),
    .stage_sof(stage_sof), .pixel_out(o_pix[1]), .pixel_valid_out(o_val[1]),
    .sof_out(o_sof[1]), .active_depth(o_act[1]), .depth_change(o_dc[1])
  );

  // Upstream filter chain stand-in: tap k is the raw stream delayed k*TAP_LAG cycles, pixel offset by 16*k.
  bit          hv [HIST];
  bit          hs [HIST];
  logic [7:0]  hp [HIST];

  // Reference model, one slot per instance.
  int   thr [3] = '{100, 140, 180};
  int   hyst [2] = '{2, 1};
  bit   m_started [2], m_waiting [2], m_muted [2];
  int   m_active [2], m_cand [2], m_hc [2], m_boost [2], m_sel [2];
  logic [7:0] m_pix [2];
  bit   m_val [2], m_sof [2], m_dc [2];

  function automatic bit tap_v(input int d);
    return (d == 0) ? pixel_valid_in : stage_valid[d-1];
  endfunction

  function automatic bit tap_s(input int d);
    return (d == 0) ? sof_in : stage_sof[d-1];
  endfunction

  function automatic logic [7:0] tap_p(input int d);
    return (d == 0) ? pixel_in : stage_pixel[d*DATA_W-1 -: DATA_W];
  endfunction

  task automatic model_reset(input int i);
    m_started[i] = 0; m_waiting[i] = 0; m_muted[i] = 1;
    m_active[i] = 0; m_cand[i] = 0; m_hc[i] = 0; m_boost[i] = 0; m_sel[i] = 0;
    m_pix[i] = '0; m_val[i] = 0; m_sof[i] = 0; m_dc[i] = 0;
  endtask

  task automatic model_step(input int i);
    int base, want_depth, sel_now;
    bit fe, boosted, trig, commit, show;
    if (!reset) begin
      model_reset(i);
      return;
    end
    fe      = sof_in && pixel_valid_in;
    boosted = (beat_detected && enable) || (m_boost[i] > 0);
    base = 1;
    foreach (thr[j]) if (int'(BPM_estimate) >= thr[j]) base++;
    want_depth = base + (boosted ? 1 : 0);
    if (want_depth > NUM_STAGES) want_depth = NUM_STAGES;
    if (!enable) want_depth = 0;

    trig    = m_waiting[i] && tap_s(m_active[i]) && tap_v(m_active[i]);
    sel_now = trig ? m_active[i] : m_sel[i];
    show    = !m_muted[i] || trig;
    m_val[i] = show && tap_v(sel_now);
    m_sof[i] = m_val[i] && tap_s(sel_now);
    if (m_val[i]) m_pix[i] = tap_p(sel_now);
    if (trig) begin
      m_sel[i] = m_active[i];
      m_muted[i] = 0;
      m_waiting[i] = 0;
    end

    commit = 0;
    if (fe) begin
      if (!m_started[i]) begin
        m_started[i] = 1; m_active[i] = want_depth; m_cand[i] = want_depth; m_hc[i] = 0; commit = 1;
      end else if (want_depth == m_active[i]) begin
        m_hc[i] = 0;
      end else begin
        if (want_depth == m_cand[i]) m_hc[i]++;
        else begin m_cand[i] = want_depth; m_hc[i] = 1; end
        if (m_hc[i] >= hyst[i]) begin m_active[i] = want_depth; m_hc[i] = 0; commit = 1; end
      end
    end
    if (commit) m_waiting[i] = 1;
    m_dc[i] = commit;

    if (beat_detected && enable) m_boost[i] = BEAT_HOLD;
    else if (fe && m_boost[i] > 0) m_boost[i]--;
  endtask

  // One clock: compare last cycle's outputs against the model, then drive the next inputs.
  task automatic step(input bit v, input bit s, input logic [7:0] p, input int bpm,
                      input bit beat, input bit en, input bit rst);
    logic [13:0] got, want;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      got  = {o_pix[i], o_val[i], o_sof[i], o_act[i], o_dc[i]};
      want = {m_pix[i], m_val[i], m_sof[i], DEPTH_W'(m_active[i]), m_dc[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_%0d hyst%0d: got pix=%h v=%b sof=%b depth=%0d dc=%b, want pix=%h v=%b sof=%b depth=%0d dc=%b",
                 cycle, hyst[i], o_pix[i], o_val[i], o_sof[i], o_act[i], o_dc[i],
                 m_pix[i], m_val[i], m_sof[i], m_active[i], m_dc[i]);
      end
      if (o_dc[i] === 1'b1) dc_seen[i]++;
    end
    cycle++;

    reset = ~rst; pixel_valid_in = v; sof_in = s; pixel_in = p;
    BPM_estimate = BPM_W'(bpm); beat_detected = beat; enable = en;
    for (int i = HIST - 1; i > 0; i--) begin
      hv[i] = hv[i-1]; hs[i] = hs[i-1]; hp[i] = hp[i-1];
    end
    hv[0] = v; hs[0] = s; hp[0] = p;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      stage_valid[k-1] = hv[k*TAP_LAG];
      stage_sof[k-1]   = hs[k*TAP_LAG];
      stage_pixel[k*DATA_W-1 -: DATA_W] = hp[k*TAP_LAG] + 8'(k * 16);
    end
    for (int i = 0; i < 2; i++) model_step(i);
  endtask

  // One frame of raw video: sof+valid on cycle 0, random valid elsewhere.
  task automatic run_frame(input int bpm, input bit en, input int beat_at, input int rst_at);
    bit v, r;
    for (int c = 0; c < FRAME_LEN; c++) begin
      v = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
      step(v, c == 0, 8'($urandom), bpm, c == beat_at, en, r);
    end
  endtask

  task automatic test_reset();
    step(0, 0, 8'h00, 0, 0, 1, 1);
    step(0, 0, 8'h00, 0, 0, 1, 1);
    checks++;
    if ({o_val, o_sof, o_dc, o_act[0], o_act[1], o_pix[0], o_pix[1]} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: val=%b sof=%b dc=%b depth=%0d/%0d, want all zero",
               o_val, o_sof, o_dc, o_act[0], o_act[1]);
    end
    step(0, 0, 8'h00, 0, 0, 1, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
  endtask

  task automatic test_first_fe();
    dc_seen[0] = 0;
    run_frame(90, 1, -1, -1);
    checks++;
    if (o_act[0] !== 3'd1 || dc_seen[0] != 1) begin
      errors++;
      $display("FAIL first_fe: depth=%0d pulses=%0d, want depth 1 pulses 1", o_act[0], dc_seen[0]);
    end
  endtask

  task automatic test_bpm_step();
    run_frame(150, 1, -1, -1);
    checks++;
    if (o_act[0] !== 3'd1 || o_act[1] !== 3'd3) begin
      errors++;
      $display("FAIL bpm_step_first: depth h2=%0d h1=%0d, want 1 and 3", o_act[0], o_act[1]);
    end
    run_frame(150, 1, -1, -1);
    checks++;
    if (o_act[0] !== 3'd3) begin
      errors++;
      $display("FAIL bpm_step_second: depth=%0d, want 3", o_act[0]);
    end
  endtask

  task automatic test_alternate();
    run_frame(90, 1, -1, -1);
    run_frame(90, 1, -1, -1);
    dc_seen[0] = 0;
    for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 95 : 105, 1, -1, -1);
    checks++;
    if (o_act[0] !== 3'd1 || dc_seen[0] != 0) begin
      errors++;
      $display("FAIL alternate_hold: depth=%0d pulses=%0d, want depth 1 pulses 0", o_act[0], dc_seen[0]);
    end
  endtask

  task automatic test_beat_boost();
    int want_b [6] = '{3, 3, 2, 4, 4, 4};
    int bpm_b  [6] = '{120, 120, 120, 190, 190, 190};
    int beat_b [6] = '{-1, -1, -1, 5, -1, 0};
    run_frame(120, 1, 5, -1);
    for (int f = 0; f < 6; f++) begin
      run_frame(bpm_b[f], 1, beat_b[f], -1);
      checks++;
      if (o_act[1] !== DEPTH_W'(want_b[f])) begin
        errors++;
        $display("FAIL beat_boost_%0d: depth=%0d, want %0d", f, o_act[1], want_b[f]);
      end
    end
  endtask

  task automatic test_enable_off();
    run_frame(150, 0, 0, -1);
    run_frame(150, 0, 5, -1);
    checks++;
    if (o_act[0] !== 3'd0 || o_act[1] !== 3'd0) begin
      errors++;
      $display("FAIL enable_off: depth h2=%0d h1=%0d, want 0", o_act[0], o_act[1]);
    end
    run_frame(90, 1, -1, -1);
    checks++;
    if (o_act[1] !== 3'd1) begin
      errors++;
      $display("FAIL enable_beat_ignored: depth=%0d, want 1", o_act[1]);
    end
  endtask

  task automatic test_thresholds();
    int bpm_t  [6] = '{99, 100, 139, 140, 179, 180};
    int want_t [6] = '{1, 2, 2, 3, 3, 4};
    for (int f = 0; f < 6; f++) begin
      run_frame(bpm_t[f], 1, -1, -1);
      checks++;
      if (o_act[1] !== DEPTH_W'(want_t[f])) begin
        errors++;
        $display("FAIL threshold_%0d: depth=%0d, want %0d", bpm_t[f], o_act[1], want_t[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_frame(90, 1, -1, 7);
    checks++;
    if (o_act[0] !== 3'd0 || o_act[1] !== 3'd0 || o_val !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: depth=%0d/%0d valid=%b, want 0/0 and 00", o_act[0], o_act[1], o_val);
    end
    run_frame(90, 1, -1, -1);
    checks++;
    if (o_act[0] !== 3'd1 || o_act[1] !== 3'd1) begin
      errors++;
      $display("FAIL reset_restart: depth=%0d/%0d, want 1/1", o_act[0], o_act[1]);
    end
  endtask

  task automatic test_random();
    int bpm, beat_at, rst_at;
    bit en;
    for (int f = 0; f < 30; f++) begin
      bpm     = $urandom_range(60, 220);
      en      = ($urandom_range(0, 9) != 0);
      beat_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME_LEN - 1));
      rst_at  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_frame(bpm, en, beat_at, rst_at);
    end
  endtask

  initial begin
    for (int i = 0; i < HIST; i++) begin hv[i] = 0; hs[i] = 0; hp[i] = '0; end
    for (int i = 0; i < 2; i++) begin model_reset(i); dc_seen[i] = 0; end
    test_reset();
    test_first_fe();
    test_bpm_step();
    test_alternate();
    test_beat_boost();
    test_enable_off();
    test_thresholds();
    test_reset_mid();
    test_random();
    step(0, 0, 8'h00, 90, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
